// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational; training, invalidation and statistics update on the clock edge.
module branch_target_predictor #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [PC_W-1:0]   lk_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    input  logic              inv_all,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CTR_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CTR_INIT = CNT_W'(1 << (CNT_W - 1));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [CNT_W-1:0]   ctr_q [ENTRIES];

    logic [STAT_W-1:0]  br_q, br_d, mp_q, mp_d;

    logic [IDX_W-1:0]   lk_idx, u_idx;
    logic [TAG_W-1:0]   lk_tag, u_tag;
    logic               lk_hit_raw, u_hit, mp_raw;

    logic               wr_en;
    logic [TAG_W-1:0]   wr_tag;
    logic [PC_W-1:0]    wr_tgt;
    logic [CNT_W-1:0]   wr_ctr;

    // The low two PC bits never participate in indexing or tagging.
    logic unused_pc_lsb;
    assign unused_pc_lsb = &{1'b0, lk_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
    assign u_idx  = upd_pc[IDX_W+1:2];
    assign u_tag  = upd_pc[PC_W-1:IDX_W+2];

    assign lk_hit_raw = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign mp_raw = upd_valid &&
                    ((upd_taken != upd_pred_taken) ||
                     (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    // Outputs are forced low while reset is held, including the pure-input mispredict path.
    assign lk_hit     = RESET && lk_hit_raw;
    assign lk_taken   = RESET && lk_hit_raw && ctr_q[lk_idx][CNT_W-1];
    assign lk_target  = (RESET && lk_hit_raw) ? tgt_q[lk_idx] : '0;
    assign mispredict = RESET && mp_raw;

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;

    always_comb begin
        wr_en  = 1'b0;
        wr_tag = tag_q[u_idx];
        wr_tgt = tgt_q[u_idx];
        wr_ctr = ctr_q[u_idx];
        if (upd_valid && !inv_all) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_ctr = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CNT_W'(1);
                    wr_tgt = upd_target;
                end else begin
                    wr_ctr = (ctr_q[u_idx] == '0) ? '0 : ctr_q[u_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                // Allocate on a taken miss, evicting whatever aliases this index.
                wr_en  = 1'b1;
                wr_tag = u_tag;
                wr_tgt = upd_target;
                wr_ctr = CTR_INIT;
            end
        end
    end

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (stat_clr) begin
            br_d = '0;
            mp_d = '0;
        end else begin
            if (upd_valid && (br_q != {STAT_W{1'b1}})) br_d = br_q + STAT_W'(1);
            if (mp_raw && (mp_q != {STAT_W{1'b1}}))    mp_d = mp_q + STAT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= wr_tag;
            tgt_q[u_idx]   <= wr_tgt;
            ctr_q[u_idx]   <= wr_ctr;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a vector table for training/aliasing/invalidate,
// then hand sequences for statistics saturation, clear and asynchronous reset.
module tb_branch_target_predictor;
    logic        CLK, RESET;
    logic [31:0] lk_pc, upd_pc, upd_target, upd_pred_target;
    logic        upd_valid, upd_taken, upd_pred_taken, inv_all, stat_clr;
    logic        lk_hit, lk_taken, mispredict;
    logic [31:0] lk_target;
    logic [15:0] stat_branches, stat_mispredicts;
    logic        s_hit, s_taken, s_mp;
    logic [31:0] s_target;
    logic [3:0]  s_br, s_mpc;

    int n_tests = 0;
    int n_fail  = 0;

    branch_target_predictor dut (
        .CLK(CLK), .RESET(RESET), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
        .lk_target(lk_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict), .inv_all(inv_all),
        .stat_clr(stat_clr), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    // Narrow-statistics instance sharing all inputs, used for the saturation check.
    branch_target_predictor #(.STAT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .lk_pc(lk_pc), .lk_hit(s_hit), .lk_taken(s_taken),
        .lk_target(s_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(s_mp), .inv_all(inv_all),
        .stat_clr(stat_clr), .stat_branches(s_br), .stat_mispredicts(s_mpc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        upt;
        logic [31:0] uptg;
        logic        inv;
        logic        clr;
        logic [31:0] lpc;
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic        mp;
        logic [15:0] br;
        logic [15:0] mpc;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utg,
                                logic upt, logic [31:0] uptg, logic inv, logic clr,
                                logic [31:0] lpc, logic hit, logic tk, logic [31:0] tgt,
                                logic mp, logic [15:0] br, logic [15:0] mpc);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.upt = upt; v.uptg = uptg;
        v.inv = inv; v.clr = clr; v.lpc = lpc; v.hit = hit; v.tk = tk; v.tgt = tgt;
        v.mp = mp; v.br = br; v.mpc = mpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input logic [31:0] lpc);
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_pred_taken = 0; upd_pred_target = 0; inv_all = 0; stat_clr = 0; lk_pc = lpc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //           uv upc      ut utg      upt uptg     inv clr lpc      hit tk tgt      mp br mpc
        vecs[0]  = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  0, 0, 32'h0,   0, 0, 0);
        vecs[1]  = mk(1, 32'h44,  1, 32'h100, 0, 32'h0,   0, 0, 32'h44,  0, 0, 32'h0,   1, 0, 0);
        vecs[2]  = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  1, 1, 32'h100, 0, 1, 1);
        vecs[3]  = mk(1, 32'h44,  1, 32'h100, 1, 32'h100, 0, 0, 32'h44,  1, 1, 32'h100, 0, 1, 1);
        vecs[4]  = mk(1, 32'h44,  1, 32'h100, 1, 32'h100, 0, 0, 32'h44,  1, 1, 32'h100, 0, 2, 1);
        vecs[5]  = mk(1, 32'h44,  1, 32'h100, 1, 32'h100, 0, 0, 32'h44,  1, 1, 32'h100, 0, 3, 1);
        vecs[6]  = mk(1, 32'h44,  0, 32'h0,   1, 32'h100, 0, 0, 32'h44,  1, 1, 32'h100, 1, 4, 1);
        vecs[7]  = mk(1, 32'h44,  0, 32'h0,   1, 32'h100, 0, 0, 32'h44,  1, 1, 32'h100, 1, 5, 2);
        vecs[8]  = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  1, 0, 32'h100, 0, 6, 3);
        vecs[9]  = mk(1, 32'h44,  1, 32'h100, 0, 32'h0,   0, 0, 32'h44,  1, 0, 32'h100, 1, 6, 3);
        vecs[10] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  1, 1, 32'h100, 0, 7, 4);
        vecs[11] = mk(1, 32'h444, 1, 32'h200, 0, 32'h0,   0, 0, 32'h444, 0, 0, 32'h0,   1, 7, 4);
        vecs[12] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  0, 0, 32'h0,   0, 8, 5);
        vecs[13] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h444, 1, 1, 32'h200, 0, 8, 5);
        vecs[14] = mk(1, 32'h444, 1, 32'h180, 1, 32'h100, 0, 0, 32'h444, 1, 1, 32'h200, 1, 8, 5);
        vecs[15] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h444, 1, 1, 32'h180, 0, 9, 6);
        vecs[16] = mk(1, 32'h44,  1, 32'h300, 0, 32'h0,   1, 0, 32'h444, 1, 1, 32'h180, 1, 9, 6);
        vecs[17] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h444, 0, 0, 32'h0,   0, 10, 7);
        vecs[18] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h44,  0, 0, 32'h0,   0, 10, 7);
        vecs[19] = mk(1, 32'h44,  0, 32'h0,   0, 32'h0,   0, 1, 32'h44,  0, 0, 32'h0,   0, 10, 7);
        vecs[20] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0);

        // Reset held with a mispredicting update on the inputs: every output must stay 0.
        idle(32'h44);
        RESET = 0;
        upd_valid = 1; upd_pc = 32'h44; upd_taken = 1; upd_target = 32'h100;
        #1;
        chk("rst_hit", {31'b0, lk_hit}, 0);
        chk("rst_taken", {31'b0, lk_taken}, 0);
        chk("rst_target", lk_target, 0);
        chk("rst_mispredict", {31'b0, mispredict}, 0);
        chk("rst_branches", {16'b0, stat_branches}, 0);
        chk("rst_mispredicts", {16'b0, stat_mispredicts}, 0);
        idle(32'h44);
        tick();
        tick();
        RESET = 1;

        for (int i = 0; i < 21; i++) begin
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            upd_target = vecs[i].utg; upd_pred_taken = vecs[i].upt;
            upd_pred_target = vecs[i].uptg; inv_all = vecs[i].inv; stat_clr = vecs[i].clr;
            lk_pc = vecs[i].lpc;
            #1;
            chk($sformatf("v%0d_hit", i), {31'b0, lk_hit}, {31'b0, vecs[i].hit});
            chk($sformatf("v%0d_taken", i), {31'b0, lk_taken}, {31'b0, vecs[i].tk});
            chk($sformatf("v%0d_target", i), lk_target, vecs[i].tgt);
            chk($sformatf("v%0d_mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].mp});
            chk($sformatf("v%0d_branches", i), {16'b0, stat_branches}, {16'b0, vecs[i].br});
            chk($sformatf("v%0d_mispredicts", i), {16'b0, stat_mispredicts}, {16'b0, vecs[i].mpc});
            tick();
        end

        // 20 mispredicted updates: 16-bit stats reach 20, 4-bit stats stick at F.
        idle(32'h44);
        for (int i = 0; i < 20; i++) begin
            upd_valid = 1; upd_pc = 32'h44; upd_taken = 1; upd_target = 32'h100;
            upd_pred_taken = 0;
            tick();
        end
        idle(32'h44);
        #1;
        chk("sat_br16", {16'b0, stat_branches}, 20);
        chk("sat_mp16", {16'b0, stat_mispredicts}, 20);
        chk("sat_br4", {28'b0, s_br}, 32'hF);
        chk("sat_mp4", {28'b0, s_mpc}, 32'hF);
        chk("sat_hit", {31'b0, lk_hit}, 1);

        // Clear wins over a same-cycle mispredicted update.
        upd_valid = 1; upd_pc = 32'h44; upd_taken = 0; upd_pred_taken = 1; stat_clr = 1;
        tick();
        idle(32'h44);
        #1;
        chk("clr_br16", {16'b0, stat_branches}, 0);
        chk("clr_mp16", {16'b0, stat_mispredicts}, 0);
        chk("clr_br4", {28'b0, s_br}, 0);
        chk("clr_mp4", {28'b0, s_mpc}, 0);

        // One counted update, then reset asserted mid-cycle with an allocating update pending.
        upd_valid = 1; upd_pc = 32'h88; upd_taken = 1; upd_target = 32'h500; upd_pred_taken = 0;
        tick();
        lk_pc = 32'h88;
        #1;
        chk("pre_rst_hit", {31'b0, lk_hit}, 1);
        chk("pre_rst_br", {16'b0, stat_branches}, 1);
        upd_pc = 32'h8C;
        RESET = 0;
        #1;
        chk("async_hit", {31'b0, lk_hit}, 0);
        chk("async_target", lk_target, 0);
        chk("async_mispredict", {31'b0, mispredict}, 0);
        chk("async_br", {16'b0, stat_branches}, 0);
        tick();
        RESET = 1;
        idle(32'h8C);
        #1;
        chk("post_rst_lost_upd", {31'b0, lk_hit}, 0);
        lk_pc = 32'h88;
        #1;
        chk("post_rst_old_entry", {31'b0, lk_hit}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
